// File: rtl/bias_relu.sv
// Adds a per-row bias to each matrix element and applies ReLU, one element per cycle in row-major order.
// Latency: done rises ROWS*COLS edges after capture; define BIAS_RELU_SATURATE_EN to saturate the add.
module bias_relu #(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] matrix_in [ROWS][COLS],
    input  logic [31:0] bias      [ROWS],
    output logic [31:0] result    [ROWS][COLS],
    output logic        busy,
    output logic        done
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PROCESS = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [31:0] in_q   [ROWS][COLS];
    logic [31:0] bias_q [ROWS];

    logic        last_elem;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] sum;
    logic [31:0] sum_fin;
    logic [31:0] act;

    assign last_elem = (row == RW'(ROWS - 1)) && (col == CW'(COLS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DONE only exits on enable low, so a held upstream done cannot retrigger a run.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable)    state_nxt = PROCESS;
            PROCESS: if (last_elem) state_nxt = DONE;
            DONE:    if (!enable)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == PROCESS);
        done = (state == DONE);
    end

    always_comb begin
        op_a = in_q[row][col];
        op_b = bias_q[row];
        sum  = op_a + op_b;
`ifdef BIAS_RELU_SATURATE_EN
        if ((op_a[31] == op_b[31]) && (sum[31] != op_a[31])) begin
            sum_fin = op_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            sum_fin = sum;
        end
`else
        sum_fin = sum;
`endif
        act = sum_fin[31] ? 32'd0 : sum_fin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
            for (int r = 0; r < ROWS; r++) begin
                bias_q[r] <= '0;
                for (int c = 0; c < COLS; c++) begin
                    in_q[r][c]   <= '0;
                    result[r][c] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        row <= '0;
                        col <= '0;
                        for (int r = 0; r < ROWS; r++) begin
                            bias_q[r] <= bias[r];
                            for (int c = 0; c < COLS; c++) begin
                                in_q[r][c]   <= matrix_in[r][c];
                                result[r][c] <= '0;
                            end
                        end
                    end
                end
                PROCESS: begin
                    result[row][col] <= act;
                    if (last_elem) begin
                        row <= '0;
                        col <= '0;
                    end else if (col == CW'(COLS - 1)) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bias_relu.md
BIAS_RELU -- requirements
Module: bias_relu

Interface
REQ-001 The block SHALL have parameter ROWS, default 4, giving the number of rows in the input matrix and the number of bias entries.
REQ-002 The block SHALL have parameter COLS, default 4, giving the number of columns in the input matrix.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port enable, input, 1 bit: level start request, driven directly by the upstream matrix-multiply done.
REQ-006 The block SHALL have port matrix_in, input, 32 bits x [ROWS][COLS]: the product matrix, signed two's complement.
REQ-007 The block SHALL have port bias, input, 32 bits x [ROWS]: the per-row bias, signed two's complement.
REQ-008 The block SHALL have port result, output, 32 bits x [ROWS][COLS]: the registered activated matrix.
REQ-009 The block SHALL have port busy, output, 1 bit: high while elements are being processed.
REQ-010 The block SHALL have port done, output, 1 bit: high while result is complete and enable is still high.

Function
REQ-011 The block SHALL implement states IDLE, PROCESS and DONE.
REQ-012 In IDLE, when enable=1 is sampled, the block SHALL capture matrix_in and bias into internal registers, clear all of result to 0, set the element index to 0 and enter PROCESS.
REQ-013 In PROCESS, the block SHALL compute one element per cycle in row-major order (r=0..ROWS-1 outer, c=0..COLS-1 inner): y = in[r][c] + bias[r], then result[r][c] = (y < 0) ? 0 : y.
REQ-014 The add SHALL be a 32-bit signed add; without REQ-024 it wraps modulo 2^32 before the ReLU is applied.
REQ-015 On the edge that writes the last element (r=ROWS-1, c=COLS-1), the block SHALL enter DONE with done=1 and busy=0; done is therefore first high ROWS*COLS edges after the capture edge.
REQ-016 busy SHALL be 1 exactly in PROCESS.
REQ-017 A change of matrix_in or bias after capture SHALL NOT affect the current run.
REQ-018 If enable deasserts during PROCESS, the block SHALL complete the run, enter DONE, and return to IDLE on the next edge; done is then high for exactly one cycle.
REQ-019 In DONE, the block SHALL hold done=1 while enable=1 and enter IDLE with done=0 on the first edge that samples enable=0.
REQ-020 result SHALL hold its values from IDLE until the next capture edge.
REQ-021 A new run SHALL start only after enable is sampled low at least once, because DONE requires enable=0 to exit; this prevents retriggering on a held upstream done.

Reset
REQ-022 When rst=1 is sampled, the block SHALL clear state to IDLE, the index to 0, done=0, busy=0, all result to 0 and all captured registers to 0.
REQ-023 rst SHALL take priority over every other condition, including mid-PROCESS and DONE; after rst is released, the block waits in IDLE for enable.

Configuration
REQ-024 When macro BIAS_RELU_SATURATE_EN is defined, the add SHALL saturate: a positive overflow yields 32'h7FFF_FFFF and a negative overflow yields 32'h8000_0000 (then 0 after ReLU). When the macro is not defined, the add SHALL wrap as stated in REQ-014.

Verification
REQ-025 Basic run: ROWS=COLS=2, in={{5,-3},{-10,7}}, bias={1,4}, enable held -> result {{6,0},{0,11}}; done high on the 4th edge after capture; busy high for 4 cycles.
REQ-026 Enable handshake: enable high for 1 cycle only -> the run completes, done pulses for 1 cycle, state returns to IDLE; with enable held high, done stays high and no second run starts until enable goes low and then high.
REQ-027 Overflow: in[0][0]=32'h7FFF_FFFF, bias[0]=1 -> result[0][0]=32'h7FFF_FFFF with BIAS_RELU_SATURATE_EN defined, and 0 (wrapped negative, then ReLU) without it.
REQ-028 Reset mid-run: assert rst at the 2nd PROCESS cycle -> the next edge gives result all 0, busy=0, done=0; a rerun after release gives the correct result.
REQ-029 Input change: modify matrix_in and bias on the edge after capture -> result reflects the captured values only.
